gray_seq_counter: RTL

- Sequencing counter that produces the binary stimulus word for the downstream binary-to-Gray conversion stage.
- It also emits the matching registered Gray code, so downstream logic sees a glitch-free Gray value aligned with the binary value.
- Supports up/down counting, parallel load, and free-run or one-shot operation. One-shot operation is controlled by a small start/stop state machine.

---
 rtl/dld_pkg.sv | 15 +
 rtl/gray_encode.sv | 11 +
 rtl/gray_seq_counter.sv | 79 +++++++
 3 files changed

// File: rtl/dld_pkg.sv
// dld_pkg: shared state encoding, default width and Gray helper for the sequencing counter.
package dld_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Callers zero-extend narrower codes and truncate the result.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction
endpackage

// File: rtl/gray_encode.sv
// gray_encode: combinational binary-to-Gray conversion of a WIDTH-bit word.
module gray_encode
    import dld_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray
);
    assign o_gray = WIDTH'(bin2gray(32'(i_bin)));
endmodule

// File: rtl/gray_seq_counter.sv
// gray_seq_counter: up/down sequencing counter with load, one-shot FSM and aligned registered Gray output.
module gray_seq_counter
    import dld_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] limit,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap,
    output logic             busy,
    output logic             done
);
    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;
    logic [WIDTH-1:0] w_next_bin;
    logic [WIDTH-1:0] w_next_gray;
    logic             w_next_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_gray  <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_bin   <= w_next_bin;
            r_gray  <= w_next_gray;
            r_wrap  <= w_next_wrap;
        end
    end

    // Priority: load > stop > start > count; start inside RUN falls through to counting.
    always_comb begin
        w_next_state = r_state;
        w_next_bin   = r_bin;
        w_next_wrap  = 1'b0;
        if (load) begin
            w_next_bin   = load_val;
            w_next_state = IDLE;
        end else if (stop) begin
            w_next_state = IDLE;
        end else if (start && r_state != RUN) begin
            w_next_state = RUN;
        end else if (r_state == RUN && en) begin
            if (oneshot && r_bin == limit) begin
                w_next_state = DONE;
            end else begin
                w_next_bin  = up ? r_bin + 1'b1 : r_bin - 1'b1;
                w_next_wrap = up ? &r_bin : ~|r_bin;
            end
        end
    end

    // Encoding next_bin keeps gray_out registered on the same edge as bin_out.
    gray_encode #(.WIDTH(WIDTH)) u_gray_encode (
        .i_bin  (w_next_bin),
        .o_gray (w_next_gray)
    );

    assign bin_out  = r_bin;
    assign gray_out = r_gray;
    assign wrap     = r_wrap;
    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);
endmodule
